// File: rtl/core_run_controller.sv
// ============================================================================
// Module   : core_run_controller
// Brief    : Load/run/step/halt sequencer for the single-cycle core. Owns the
//            instruction-memory write port during LOAD and gates PC advance
//            (core_en) during execution.
// Options  : define CORE_RUN_BREAKPOINT_EN to add a single PC breakpoint
//            (ports i_bp_valid / i_bp_addr) that stops free-running execution.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_run_controller #(
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 16,
  parameter int unsigned END_PC = 32'hFF,
  parameter int          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load_start,
  input  logic              i_load_valid,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_done,
  output logic              o_load_ready,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_halt_req,
  input  logic [ADDR_W-1:0] i_pc_in,
`ifdef CORE_RUN_BREAKPOINT_EN
  input  logic              i_bp_valid,
  input  logic [ADDR_W-1:0] i_bp_addr,
`endif
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [DATA_W-1:0] o_imem_wdata,
  output logic              o_core_en,
  output logic              o_pc_clear,
  output logic              o_halted,
  output logic [2:0]        o_state,
  output logic [CNT_W-1:0]  o_instr_count,
  output logic [ADDR_W:0]   o_words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] c_END_PC = END_PC[ADDR_W-1:0];
  // words_loaded can reach a full memory of 2^ADDR_W entries
  localparam logic [ADDR_W:0]   c_WL_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  logic [CNT_W-1:0]  r_instr_count;
  logic [ADDR_W:0]   r_words_loaded;

  logic              w_pc_end;
  logic              w_bp_hit;
  logic              w_stop_run;
  logic              w_core_en;
  logic              w_in_load;

`ifdef CORE_RUN_BREAKPOINT_EN
  // Masks the breakpoint on the first RUN cycle after a resume from HALT so
  // that continuing from a breakpoint executes the instruction it stopped on.
  logic              r_bp_mask;
  assign w_bp_hit = i_bp_valid && (i_pc_in == i_bp_addr) && !r_bp_mask;
`else
  assign w_bp_hit = 1'b0;
`endif

  // Execution gating: the instruction at a stop PC is never executed
  always_comb begin
    w_pc_end   = (i_pc_in == c_END_PC);
    w_stop_run = i_halt_req | w_pc_end | w_bp_hit;
    w_core_en  = 1'b0;
    case (r_state)
      S_RUN:   w_core_en = ~w_stop_run;
      S_STEP:  w_core_en = ~(i_halt_req | w_pc_end);
      default: w_core_en = 1'b0;
    endcase
    if (reset) begin
      w_core_en = 1'b0;
    end
  end

  // Sequencer state, executed-instruction counter and load word counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_instr_count  <= '0;
      r_words_loaded <= '0;
`ifdef CORE_RUN_BREAKPOINT_EN
      r_bp_mask      <= 1'b0;
`endif
    end else begin
      if (w_core_en && (r_instr_count != {CNT_W{1'b1}})) begin
        r_instr_count <= r_instr_count + 1'b1;
      end
`ifdef CORE_RUN_BREAKPOINT_EN
      r_bp_mask <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (i_load_start) begin
            r_state        <= S_LOAD;
            r_words_loaded <= '0;
            r_instr_count  <= '0;
          end else if (i_run) begin
            r_state <= S_RUN;
          end else if (i_step) begin
            r_state <= S_STEP;
          end
        end
        S_LOAD: begin
          if (i_load_valid && (r_words_loaded != c_WL_MAX)) begin
            r_words_loaded <= r_words_loaded + 1'b1;
          end
          if (i_load_done) begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_stop_run) begin
            r_state <= S_HALT;
          end
        end
        S_STEP: begin
          r_state <= S_HALT;
        end
        S_HALT: begin
          if (i_load_start) begin
            r_state        <= S_LOAD;
            r_words_loaded <= '0;
            r_instr_count  <= '0;
          end else if (i_run) begin
            r_state <= S_RUN;
`ifdef CORE_RUN_BREAKPOINT_EN
            r_bp_mask <= 1'b1;
`endif
          end else if (i_step) begin
            r_state <= S_STEP;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write port is only live in LOAD and is suppressed during reset
  assign w_in_load    = (r_state == S_LOAD) && !reset;
  assign o_imem_we    = w_in_load & i_load_valid;
  assign o_imem_addr  = w_in_load ? i_load_addr : '0;
  assign o_imem_wdata = w_in_load ? i_load_data : '0;

  assign o_load_ready   = (r_state == S_LOAD);
  assign o_pc_clear     = !((r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_HALT));
  assign o_halted       = (r_state == S_HALT);
  assign o_core_en      = w_core_en;
  assign o_state        = r_state;
  assign o_instr_count  = r_instr_count;
  assign o_words_loaded = r_words_loaded;

endmodule

`default_nettype wire

// File: tb/tb_core_run_controller.sv
// ============================================================================
// Module   : tb_core_run_controller
// Brief    : Self-checking bench for core_run_controller. Expected memory
//            writes and expected executed PCs are queued as stimulus is
//            driven and consumed by negedge monitors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_run_controller;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_start, load_valid, load_done;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              run, step, halt_req;
  logic [ADDR_W-1:0] pc_in;
`ifdef CORE_RUN_BREAKPOINT_EN
  logic              bp_valid;
  logic [ADDR_W-1:0] bp_addr;
`endif
  logic              load_ready, imem_we, core_en, pc_clear, halted;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic [2:0]        state;
  logic [CNT_W-1:0]  instr_count;
  logic [ADDR_W:0]   words_loaded;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;
  int wr_seen  = 0;

  logic [ADDR_W+DATA_W-1:0] wr_q[$];
  logic [ADDR_W-1:0]        ex_q[$];

  core_run_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .END_PC(32'hFF), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_load_start  (load_start),
    .i_load_valid  (load_valid),
    .i_load_addr   (load_addr),
    .i_load_data   (load_data),
    .i_load_done   (load_done),
    .o_load_ready  (load_ready),
    .i_run         (run),
    .i_step        (step),
    .i_halt_req    (halt_req),
    .i_pc_in       (pc_in),
`ifdef CORE_RUN_BREAKPOINT_EN
    .i_bp_valid    (bp_valid),
    .i_bp_addr     (bp_addr),
`endif
    .o_imem_we     (imem_we),
    .o_imem_addr   (imem_addr),
    .o_imem_wdata  (imem_wdata),
    .o_core_en     (core_en),
    .o_pc_clear    (pc_clear),
    .o_halted      (halted),
    .o_state       (state),
    .o_instr_count (instr_count),
    .o_words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    wr_q.push_back({a, d});
  endtask

  task automatic push_ex(input logic [ADDR_W-1:0] p);
    pc_in = p;
    ex_q.push_back(p);
    exp_cnt++;
  endtask

  // Write monitor: every imem write must match the next queued word
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_seen++;
      if (wr_q.size() == 0) chk("imem_we_unexpected", 32'd1, 32'd0);
      else chk("imem_write", {8'd0, imem_addr, imem_wdata}, {8'd0, wr_q.pop_front()});
    end
  end

  // Execute monitor: every core_en cycle must match the next queued PC
  always @(negedge clk) begin
    if (core_en === 1'b1) begin
      if (ex_q.size() == 0) chk("core_en_unexpected", 32'd1, 32'd0);
      else chk("exec_pc", {24'd0, pc_in}, {24'd0, ex_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_start = 0; load_valid = 0; load_done = 0;
    load_addr = '0; load_data = '0; run = 0; step = 0; halt_req = 0; pc_in = '0;
`ifdef CORE_RUN_BREAKPOINT_EN
    bp_valid = 0; bp_addr = '0;
`endif
    tick(); tick();
    @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_instr_count", {16'd0, instr_count}, 32'd0);
    chk("rst_words_loaded", {23'd0, words_loaded}, 32'd0);
    chk("rst_pc_clear", {31'd0, pc_clear}, 32'd1);
    chk("rst_core_en", {31'd0, core_en}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd0);

    // ---- program load: three words then load_done
    tick();
    reset = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    begin
      logic [15:0] words[3];
      words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
      for (int i = 0; i < 3; i++) begin
        push_wr(ADDR_W'(i), words[i]);
        @(negedge clk);
        chk("load_ready", {31'd0, load_ready}, 32'd1);
        tick();
      end
    end
    load_valid = 1'b0;
    load_done  = 1'b1;
    @(negedge clk);
    chk("load_words_3", {23'd0, words_loaded}, 32'd3);
    tick();
    load_done = 1'b0;
    @(negedge clk);
    chk("load_back_idle", {29'd0, state}, 32'd0);
    chk("load_write_count", wr_seen, 32'd3);

    // ---- run to END_PC
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int p = 0; p < 255; p++) begin
      push_ex(ADDR_W'(p));
      tick();
    end
    pc_in = 8'hFF;
    @(negedge clk);
    chk("end_pc_core_en", {31'd0, core_en}, 32'd0);
    tick();
    @(negedge clk);
    chk("end_halted", {31'd0, halted}, 32'd1);
    chk("end_state", {29'd0, state}, 32'd4);
    chk("end_instr_count", {16'd0, instr_count}, 32'd255);
    chk("halt_pc_clear", {31'd0, pc_clear}, 32'd0);

    // ---- single step
    pc_in = 8'd3;
    step  = 1'b1;
    tick();
    step = 1'b0;
    push_ex(8'd3);
    @(negedge clk);
    chk("step_state", {29'd0, state}, 32'd3);
    chk("step_core_en", {31'd0, core_en}, 32'd1);
    tick();
    @(negedge clk);
    chk("step_back_halt", {29'd0, state}, 32'd4);
    chk("step_instr_count", {16'd0, instr_count}, exp_cnt);

    // ---- halt_req then resume
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int p = 0; p < 10; p++) begin
      push_ex(ADDR_W'(p));
      tick();
    end
    pc_in = 8'd10;
    halt_req = 1'b1;
    @(negedge clk);
    chk("halt_req_core_en", {31'd0, core_en}, 32'd0);
    tick();
    halt_req = 1'b0;
    @(negedge clk);
    chk("halt_req_state", {29'd0, state}, 32'd4);
    chk("halt_req_pc_clear", {31'd0, pc_clear}, 32'd0);
    run = 1'b1;
    tick();
    run = 1'b0;
    push_ex(8'd10);
    @(negedge clk);
    chk("resume_state", {29'd0, state}, 32'd2);
    chk("resume_core_en", {31'd0, core_en}, 32'd1);
    tick();
    halt_req = 1'b1;
    pc_in = 8'd11;
    tick();
    halt_req = 1'b0;
    @(negedge clk);
    chk("resume_halt_again", {29'd0, state}, 32'd4);

    // ---- step held high: STEP/HALT alternate
    pc_in = 8'd20;
    step  = 1'b1;
    tick();
    push_ex(8'd20);
    tick();
    tick();
    push_ex(8'd20);
    tick();
    step = 1'b0;
    @(negedge clk);
    chk("step_held_state", {29'd0, state}, 32'd4);
    chk("step_held_count", {16'd0, instr_count}, exp_cnt);

    // ---- load from HALT, run ignored in LOAD, word in load_done cycle
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    exp_cnt = 0;
    run = 1'b1;
    push_wr(8'd7, 16'hBEEF);
    @(negedge clk);
    chk("load_entry_count_clr", {16'd0, instr_count}, 32'd0);
    chk("load_entry_words_clr", {23'd0, words_loaded}, 32'd0);
    tick();
    run = 1'b0;
    push_wr(8'd8, 16'hCAFE);
    load_done = 1'b1;
    @(negedge clk);
    chk("load_ignores_run", {29'd0, state}, 32'd1);
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
    @(negedge clk);
    chk("load_done_state", {29'd0, state}, 32'd0);
    chk("load_done_word_kept", {23'd0, words_loaded}, 32'd2);

    // ---- reset during LOAD suppresses the write
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    push_wr(8'd1, 16'h1111);
    tick();
    reset = 1'b1;
    load_addr = 8'd2; load_data = 16'h2222;
    @(negedge clk);
    chk("reset_we_blocked", {31'd0, imem_we}, 32'd0);
    tick();
    reset = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    chk("reset_load_state", {29'd0, state}, 32'd0);
    chk("reset_load_words", {23'd0, words_loaded}, 32'd0);

`ifdef CORE_RUN_BREAKPOINT_EN
    // ---- breakpoint stops RUN, resume passes it
    bp_addr  = 8'd5;
    bp_valid = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int p = 0; p < 5; p++) begin
      push_ex(ADDR_W'(p));
      tick();
    end
    pc_in = 8'd5;
    @(negedge clk);
    chk("bp_core_en", {31'd0, core_en}, 32'd0);
    tick();
    @(negedge clk);
    chk("bp_halted", {29'd0, state}, 32'd4);
    run = 1'b1;
    tick();
    run = 1'b0;
    push_ex(8'd5);
    @(negedge clk);
    chk("bp_resume_core_en", {31'd0, core_en}, 32'd1);
    tick();
    push_ex(8'd6);
    tick();
    halt_req = 1'b1;
    pc_in = 8'd7;
    tick();
    halt_req = 1'b0;
    bp_valid = 1'b0;
    @(negedge clk);
    chk("bp_final_state", {29'd0, state}, 32'd4);
`endif

    chk("wr_queue_drained", wr_q.size(), 32'd0);
    chk("exec_queue_drained", ex_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
